// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the DataMemory port around the arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface dmem_port_arbiter_if #(
  parameter int N = 64
);
  localparam int BYTES = N / 8;

  // Port 0: core LSU
  logic             p0_valid;
  logic             p0_ready;
  logic             p0_write;
  logic [N-1:0]     p0_addr;
  logic [N-1:0]     p0_wdata;
  logic [BYTES-1:0] p0_wmask;
  logic             p0_rvalid;
  logic [N-1:0]     p0_rdata;

  // Port 1: debug/DMA master
  logic             p1_valid;
  logic             p1_ready;
  logic             p1_write;
  logic [N-1:0]     p1_addr;
  logic [N-1:0]     p1_wdata;
  logic [BYTES-1:0] p1_wmask;
  logic             p1_rvalid;
  logic [N-1:0]     p1_rdata;

  // DataMemory side
  logic             mem_writeEnable;
  logic [N-1:0]     mem_address;
  logic [N-1:0]     mem_writeData;
  logic [BYTES-1:0] mem_writeMask;
  logic [N-1:0]     mem_readDatabus;

  modport slave (
    input  p0_valid, p0_write, p0_addr, p0_wdata, p0_wmask,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_valid, p1_write, p1_addr, p1_wdata, p1_wmask,
    output p1_ready, p1_rvalid, p1_rdata,
    output mem_writeEnable, mem_address, mem_writeData, mem_writeMask,
    input  mem_readDatabus
  );

  modport master (
    output p0_valid, p0_write, p0_addr, p0_wdata, p0_wmask,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_valid, p1_write, p1_addr, p1_wdata, p1_wmask,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  mem_writeEnable, mem_address, mem_writeData, mem_writeMask,
    output mem_readDatabus
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single DataMemory port. Round-robin with
// bounded bursts, combinational grant, one-cycle registered read response.
module dmem_port_arbiter #(
  parameter int N         = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_port_arbiter_if.slave    bus
);
  localparam int BYTES = N / 8;
  localparam int CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            last_q, last_d;
  logic            rv0_q, rv1_q;
  logic [N-1:0]    rdata0_q, rdata1_q;

  logic            gnt_vld;
  logic            gnt;
  logic            xfer;
  logic            gnt_write;

  // Burst counter stops at MAX_BURST while the owner keeps an uncontested grant.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + CW'(1);
  endfunction

  // Owner/burst state and last-grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Grant selection, memory mux, handshake outputs and next state.
  always_comb begin
    gnt_vld             = 1'b0;
    gnt                 = 1'b0;
    state_d             = IDLE;
    burst_d             = '0;
    last_d              = last_q;
    bus.p0_ready        = 1'b0;
    bus.p1_ready        = 1'b0;
    bus.mem_writeEnable = 1'b0;
    bus.mem_address     = '0;
    bus.mem_writeData   = '0;
    bus.mem_writeMask   = '0;
    gnt_write           = 1'b0;

    // Current owner keeps the port until its burst is spent and the other side waits.
    if (state_q == OWN0 && bus.p0_valid && (burst_q < BURST_MAX || !bus.p1_valid)) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (state_q == OWN1 && bus.p1_valid && (burst_q < BURST_MAX || !bus.p0_valid)) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end else if (bus.p0_valid && bus.p1_valid) begin
      gnt_vld = 1'b1;
      gnt     = ~last_q;
    end else if (bus.p0_valid) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
    end else if (bus.p1_valid) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end

    xfer = gnt_vld & ~rst;

    if (xfer) begin
      if (gnt) begin
        bus.p1_ready        = 1'b1;
        gnt_write           = bus.p1_write;
        bus.mem_writeEnable = bus.p1_write & (|bus.p1_wmask);
        bus.mem_address     = bus.p1_addr;
        bus.mem_writeData   = bus.p1_wdata;
        bus.mem_writeMask   = bus.p1_wmask;
      end else begin
        bus.p0_ready        = 1'b1;
        gnt_write           = bus.p0_write;
        bus.mem_writeEnable = bus.p0_write & (|bus.p0_wmask);
        bus.mem_address     = bus.p0_addr;
        bus.mem_writeData   = bus.p0_wdata;
        bus.mem_writeMask   = bus.p0_wmask;
      end
      state_d = gnt ? OWN1 : OWN0;
      last_d  = gnt;
      if ((gnt && state_q == OWN1) || (!gnt && state_q == OWN0)) begin
        burst_d = sat_inc(burst_q);
      end else begin
        burst_d = CW'(1);
      end
    end
  end

  // Load response: capture memory data at the transfer edge, pulse rvalid next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rv0_q <= xfer & ~gnt & ~gnt_write;
      rv1_q <= xfer &  gnt & ~gnt_write;
      if (xfer && !gnt && !gnt_write) rdata0_q <= bus.mem_readDatabus;
      if (xfer &&  gnt && !gnt_write) rdata1_q <= bus.mem_readDatabus;
    end
  end

  // Reset masks responses immediately, including one already in flight.
  always_comb begin
    bus.p0_rvalid = rv0_q & ~rst;
    bus.p1_rvalid = rv1_q & ~rst;
    bus.p0_rdata  = rst ? '0 : rdata0_q;
    bus.p1_rdata  = rst ? '0 : rdata1_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural DataMemory
// (combinational read, byte-masked write on posedge).
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.N(64)) bus ();

  dmem_port_arbiter #(.N(64), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // DataMemory model: 16 words, word index from address bits 6:3.
  logic [63:0] mem [16] = '{default: 64'h0};
  logic [3:0]  widx;
  assign widx = bus.mem_address[6:3];
  assign bus.mem_readDatabus = mem[widx];

  always @(posedge clk) begin
    if (bus.mem_writeEnable) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.mem_writeMask[b]) mem[widx][b*8 +: 8] <= bus.mem_writeData[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    bus.p0_valid = v; bus.p0_write = w; bus.p0_addr = a;
    bus.p0_wdata = d; bus.p0_wmask = m;
  endtask

  task automatic drive1(input logic v, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    bus.p1_valid = v; bus.p1_write = w; bus.p1_addr = a;
    bus.p1_wdata = d; bus.p1_wmask = m;
  endtask

  initial begin
    drive0(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    drive1(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_ready",  {63'b0, bus.p0_ready}, 64'h0);
    chk("rst_p1_ready",  {63'b0, bus.p1_ready}, 64'h0);
    chk("rst_p0_rvalid", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("rst_p1_rvalid", {63'b0, bus.p1_rvalid}, 64'h0);
    chk("rst_p0_rdata",  bus.p0_rdata, 64'h0);
    chk("rst_mem_we",    {63'b0, bus.mem_writeEnable}, 64'h0);

    // 1: p0 full store then load back
    @(negedge clk); rst = 1'b0;
    drive0(1'b1, 1'b1, 64'h0, 64'h0011223344556677, 8'hFF);
    #1;
    chk("t1_st_ready", {63'b0, bus.p0_ready}, 64'h1);
    chk("t1_st_we",    {63'b0, bus.mem_writeEnable}, 64'h1);
    chk("t1_st_wdata", bus.mem_writeData, 64'h0011223344556677);
    @(negedge clk);
    drive0(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t1_ld_ready",     {63'b0, bus.p0_ready}, 64'h1);
    chk("t1_st_no_rvalid", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("t1_ld_we",        {63'b0, bus.mem_writeEnable}, 64'h0);
    @(negedge clk);
    drive0(1'b1, 1'b1, 64'h8, 64'h0123456789ABCDEF, 8'hFF);
    #1;
    chk("t1_rvalid", {63'b0, bus.p0_rvalid}, 64'h1);
    chk("t1_rdata",  bus.p0_rdata, 64'h0011223344556677);
    chk("t1_st8_ready", {63'b0, bus.p0_ready}, 64'h1);
    @(negedge clk);
    drive0(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t1_rvalid_pulse", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("t1_idle_addr",    bus.mem_address, 64'h0);

    // 2: p1 single-byte store, load back merged word
    @(negedge clk);
    drive1(1'b1, 1'b1, 64'h0, 64'h0000000000AA0000, 8'h04);
    #1;
    chk("t2_st_ready",   {63'b0, bus.p1_ready}, 64'h1);
    chk("t2_p0_ready",   {63'b0, bus.p0_ready}, 64'h0);
    chk("t2_st_mask",    {56'b0, bus.mem_writeMask}, 64'h04);
    @(negedge clk);
    drive1(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t2_ld_ready", {63'b0, bus.p1_ready}, 64'h1);
    @(negedge clk);
    drive1(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t2_rvalid",    {63'b0, bus.p1_rvalid}, 64'h1);
    chk("t2_rdata",     bus.p1_rdata, 64'h0011223344AA6677);
    chk("t2_p0_rvalid", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("t2_p0_rdata",  bus.p0_rdata, 64'h0011223344556677);

    // 6: p1 zero-mask store completes but writes nothing
    @(negedge clk);
    drive1(1'b1, 1'b1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    #1;
    chk("t6_ready", {63'b0, bus.p1_ready}, 64'h1);
    chk("t6_we",    {63'b0, bus.mem_writeEnable}, 64'h0);
    @(negedge clk);
    drive1(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    @(negedge clk);
    drive1(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t6_rvalid", {63'b0, bus.p1_rvalid}, 64'h1);
    chk("t6_rdata",  bus.p1_rdata, 64'h0011223344AA6677);

    // 3: both requesting continuously from reset -> bursts of four, alternating
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    drive0(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    drive1(1'b1, 1'b0, 64'h8, 64'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t3_p0_ready_%0d", i), {63'b0, bus.p0_ready}, ((i / 4) % 2 == 0) ? 64'h1 : 64'h0);
      chk($sformatf("t3_p1_ready_%0d", i), {63'b0, bus.p1_ready}, ((i / 4) % 2 == 1) ? 64'h1 : 64'h0);
      @(negedge clk);
    end

    // 4: p0 drops valid after two grants; waiting p1 gets the same cycle
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("t4_p0_g1", {63'b0, bus.p0_ready}, 64'h1);
    @(negedge clk);
    #1;
    chk("t4_p0_g2", {63'b0, bus.p0_ready}, 64'h1);
    chk("t4_p1_wait", {63'b0, bus.p1_ready}, 64'h0);
    @(negedge clk);
    drive0(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t4_p1_nobubble", {63'b0, bus.p1_ready}, 64'h1);

    // 5: reset right after an accepted load kills the response
    @(negedge clk); rst = 1'b1;
    drive1(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    @(negedge clk); rst = 1'b0;
    drive0(1'b1, 1'b0, 64'h8, 64'h0, 8'h00);
    #1;
    chk("t5_ld_ready", {63'b0, bus.p0_ready}, 64'h1);
    @(negedge clk); rst = 1'b1;
    drive0(1'b1, 1'b0, 64'h8, 64'h0, 8'h00);
    #1;
    chk("t5_rvalid_killed", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("t5_rdata_zero",    bus.p0_rdata, 64'h0);
    chk("t5_ready_zero",    {63'b0, bus.p0_ready}, 64'h0);
    chk("t5_addr_zero",     bus.mem_address, 64'h0);
    @(negedge clk); rst = 1'b0;
    drive0(1'b1, 1'b0, 64'h8, 64'h0, 8'h00);
    drive1(1'b1, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t5_post_rvalid", {63'b0, bus.p0_rvalid}, 64'h0);
    chk("t5_p0_wins",     {63'b0, bus.p0_ready}, 64'h1);
    chk("t5_p1_loses",    {63'b0, bus.p1_ready}, 64'h0);
    @(negedge clk);
    drive0(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    drive1(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    #1;
    chk("t5_rdata8", bus.p0_rdata, 64'h0123456789ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
